// File: rtl/agu_ctrl_pkg.sv
// Shared types and constants for the AGU control sequencer.
// Holds the FSM state encoding, the output bundle and its state decode.
package agu_ctrl_pkg;

    localparam int LEN_W_DEF      = 16;
    localparam int ROW_W_DEF      = 8;

    localparam int MEM_HI         = 39;
    localparam int MEM_LO         = 24;
    localparam int BYTE_HI        = 23;
    localparam int BYTE_LO        = 8;
    localparam int RC_HI          = 7;
    localparam int RC_LO          = 0;

    localparam int CTRL_BYTE_MODE = 1;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        CLR       = 4'd1,
        LD_BYTE   = 4'd2,
        LD_RC     = 4'd3,
        LD_MEM    = 4'd4,
        WAIT_BEAT = 4'd5,
        STEP_BYTE = 4'd6,
        STEP_MEM  = 4'd7,
        STEP_ROW  = 4'd8,
        FINISH    = 4'd9,
        ABORT     = 4'd10
    } state_t;

    typedef struct packed {
        logic cmd_ready;
        logic busy;
        logic beat_req;
        logic clear_agu;
        logic byte_ld;
        logic rc_ld;
        logic mem_ld;
        logic byte_en;
        logic mem_en;
        logic rc_en;
        logic fb_en;
        logic done;
        logic aborted;
    } ctrl_out_t;

    // Each state asserts at most one AGU strobe, which keeps the AGU priority chain unambiguous.
    function automatic ctrl_out_t decode_state(input state_t st);
        ctrl_out_t o;
        o = '0;
        case (st)
            IDLE:      o.cmd_ready = 1'b1;
            CLR:       o.clear_agu = 1'b1;
            LD_BYTE:   o.byte_ld   = 1'b1;
            LD_RC:     o.rc_ld     = 1'b1;
            LD_MEM:    o.mem_ld    = 1'b1;
            WAIT_BEAT: o.beat_req  = 1'b1;
            STEP_BYTE: o.byte_en   = 1'b1;
            STEP_MEM:  o.mem_en    = 1'b1;
            STEP_ROW:  o.rc_en     = 1'b1;
            FINISH: begin
                o.fb_en = 1'b1;
                o.done  = 1'b1;
            end
            ABORT: begin
                o.clear_agu = 1'b1;
                o.aborted   = 1'b1;
            end
            default:   o.cmd_ready = 1'b0;
        endcase
        o.busy = (st != IDLE);
        return o;
    endfunction

endpackage

// File: rtl/agu_ctrl_cnt.sv
// Word and row counters for the AGU sequencer.
// Flags the last word and the end of a row to the FSM.
module agu_ctrl_cnt
    import agu_ctrl_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF,
    parameter int ROW_W = ROW_W_DEF
) (
    input  logic             sys_clk,
    input  logic             clear_ctrl,
    input  logic             load,
    input  logic [LEN_W-1:0] load_words,
    input  logic [ROW_W-1:0] row_words,
    input  logic             step,
    input  logic             row_clr,
    output logic             last_word,
    output logic             row_end
);

    logic [LEN_W-1:0] words_left_r;
    logic [ROW_W-1:0] row_cnt_r;

    // Word countdown and per-row word count
    always_ff @(posedge sys_clk) begin
        if (clear_ctrl) begin
            words_left_r <= '0;
            row_cnt_r    <= '0;
        end else if (load) begin
            words_left_r <= load_words;
            row_cnt_r    <= '0;
        end else if (step) begin
            words_left_r <= words_left_r - LEN_W'(1);
            row_cnt_r    <= row_cnt_r + ROW_W'(1);
        end else if (row_clr) begin
            row_cnt_r    <= '0;
        end
    end

    assign last_word = (words_left_r == '0);
    assign row_end   = (row_words != '0) && (row_cnt_r == row_words);

endmodule

// File: rtl/agu_ctrl.sv
// Transfer sequencer driving the AGU clear, load-init and step strobes,
// paced by a per-word beat handshake with the datapath.
module agu_ctrl
    import agu_ctrl_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF,
    parameter int ROW_W = ROW_W_DEF
) (
    input  logic             sys_clk,
    input  logic             clear_ctrl,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [39:0]      cmd_addresses,
    input  logic [3:0]       cmd_control,
    input  logic [LEN_W-1:0] cmd_words,
    input  logic [ROW_W-1:0] cmd_row_words,
    input  logic             abort,
    output logic             beat_req,
    input  logic             beat_ack,
    output logic [39:0]      latch_tr_addresses,
    output logic [3:0]       latch_tr_control,
    output logic             clear_agu,
    output logic             byte_gen_ldinit,
    output logic             rc_gen_ldinit,
    output logic             mem_gen_ldinit,
    output logic             byte_gen_enable,
    output logic             mem_gen_enable,
    output logic             rc_gen_enable,
    output logic             fb_gen_enable,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    state_t           state_r, state_next_s;
    ctrl_out_t        out_r;
    logic [39:0]      addr_r;
    logic [3:0]       ctrl_r;
    logic [ROW_W-1:0] row_words_r;
    logic             accept_s, last_word_s, row_end_s;

    assign accept_s = (state_r == IDLE) && cmd_valid;

    // State register; outputs are registered from the decode of the next state
    always_ff @(posedge sys_clk) begin
        if (clear_ctrl) begin
            state_r <= IDLE;
            out_r   <= decode_state(IDLE);
        end else begin
            state_r <= state_next_s;
            out_r   <= decode_state(state_next_s);
        end
    end

    // Descriptor latch, held until the next accept
    always_ff @(posedge sys_clk) begin
        if (clear_ctrl) begin
            addr_r      <= '0;
            ctrl_r      <= '0;
            row_words_r <= '0;
        end else if (accept_s) begin
            addr_r      <= cmd_addresses;
            ctrl_r      <= cmd_control;
            row_words_r <= cmd_row_words;
        end
    end

    agu_ctrl_cnt #(
        .LEN_W (LEN_W),
        .ROW_W (ROW_W)
    ) u_cnt (
        .sys_clk    (sys_clk),
        .clear_ctrl (clear_ctrl),
        .load       (accept_s),
        .load_words (cmd_words),
        .row_words  (row_words_r),
        .step       (state_r == STEP_BYTE),
        .row_clr    (state_r == STEP_ROW),
        .last_word  (last_word_s),
        .row_end    (row_end_s)
    );

    // Next-state logic; abort wins over a same-cycle beat_ack
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (cmd_valid) begin
                    state_next_s = (cmd_words == '0) ? FINISH : CLR;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CLR:       state_next_s = abort ? ABORT : LD_BYTE;
            LD_BYTE:   state_next_s = abort ? ABORT : LD_RC;
            LD_RC:     state_next_s = abort ? ABORT : LD_MEM;
            LD_MEM:    state_next_s = abort ? ABORT : WAIT_BEAT;
            WAIT_BEAT: begin
                if (abort) begin
                    state_next_s = ABORT;
                end else if (beat_ack) begin
                    state_next_s = STEP_BYTE;
                end else begin
                    state_next_s = WAIT_BEAT;
                end
            end
            STEP_BYTE: state_next_s = abort ? ABORT : STEP_MEM;
            STEP_MEM: begin
                if (abort) begin
                    state_next_s = ABORT;
                end else if (row_end_s) begin
                    state_next_s = STEP_ROW;
                end else if (last_word_s) begin
                    state_next_s = FINISH;
                end else begin
                    state_next_s = WAIT_BEAT;
                end
            end
            STEP_ROW: begin
                if (abort) begin
                    state_next_s = ABORT;
                end else if (last_word_s) begin
                    state_next_s = FINISH;
                end else begin
                    state_next_s = WAIT_BEAT;
                end
            end
            FINISH:    state_next_s = IDLE;
            ABORT:     state_next_s = IDLE;
            default:   state_next_s = IDLE;
        endcase
    end

    assign cmd_ready          = out_r.cmd_ready;
    assign busy               = out_r.busy;
    assign beat_req           = out_r.beat_req;
    assign clear_agu          = out_r.clear_agu;
    assign byte_gen_ldinit    = out_r.byte_ld;
    assign rc_gen_ldinit      = out_r.rc_ld;
    assign mem_gen_ldinit     = out_r.mem_ld;
    assign byte_gen_enable    = out_r.byte_en;
    assign mem_gen_enable     = out_r.mem_en;
    assign rc_gen_enable      = out_r.rc_en;
    assign fb_gen_enable      = out_r.fb_en;
    assign done               = out_r.done;
    assign aborted            = out_r.aborted;
    assign latch_tr_addresses = addr_r;
    assign latch_tr_control   = ctrl_r;

endmodule

// File: tb/tb_agu_ctrl.sv
// Directed bench for agu_ctrl: strobe events are scoreboarded against a queue
// filled when each command is issued; the strobe invariant is checked every cycle.
module tb_agu_ctrl;

    logic        sys_clk, clear_ctrl, cmd_valid, cmd_ready, abort, beat_req, beat_ack;
    logic [39:0] cmd_addresses, latch_tr_addresses;
    logic [3:0]  cmd_control, latch_tr_control;
    logic [15:0] cmd_words;
    logic [7:0]  cmd_row_words;
    logic        clear_agu, byte_gen_ldinit, rc_gen_ldinit, mem_gen_ldinit;
    logic        byte_gen_enable, mem_gen_enable, rc_gen_enable, fb_gen_enable;
    logic        busy, done, aborted;

    agu_ctrl dut (
        .sys_clk(sys_clk), .clear_ctrl(clear_ctrl), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addresses(cmd_addresses), .cmd_control(cmd_control), .cmd_words(cmd_words),
        .cmd_row_words(cmd_row_words), .abort(abort), .beat_req(beat_req), .beat_ack(beat_ack),
        .latch_tr_addresses(latch_tr_addresses), .latch_tr_control(latch_tr_control),
        .clear_agu(clear_agu), .byte_gen_ldinit(byte_gen_ldinit), .rc_gen_ldinit(rc_gen_ldinit),
        .mem_gen_ldinit(mem_gen_ldinit), .byte_gen_enable(byte_gen_enable),
        .mem_gen_enable(mem_gen_enable), .rc_gen_enable(rc_gen_enable),
        .fb_gen_enable(fb_gen_enable), .busy(busy), .done(done), .aborted(aborted)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Event vector: {clr, ldB, ldR, ldM, byteE, memE, rcE, fbE, done, aborted}
    localparam logic [9:0] E_CLR = 10'b1000000000;
    localparam logic [9:0] E_LDB = 10'b0100000000;
    localparam logic [9:0] E_LDR = 10'b0010000000;
    localparam logic [9:0] E_LDM = 10'b0001000000;
    localparam logic [9:0] E_BE  = 10'b0000100000;
    localparam logic [9:0] E_ME  = 10'b0000010000;
    localparam logic [9:0] E_RC  = 10'b0000001000;
    localparam logic [9:0] E_FB  = 10'b0000000110;
    localparam logic [9:0] E_AB  = 10'b1000000001;

    int         errors = 0;
    int         checks = 0;
    logic [9:0] exp_q[$];
    bit         mon_en = 1'b0;
    bit         auto_ack = 1'b1;
    int         ack_delay = 0;
    int         wait_cnt = 0;
    int         be_total = 0, rc_total = 0, br_total = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge, score events, then drive the beat responder.
    task automatic tick();
        logic [9:0] ev, e;
        @(negedge sys_clk);
        ev = {clear_agu, byte_gen_ldinit, rc_gen_ldinit, mem_gen_ldinit, byte_gen_enable,
              mem_gen_enable, rc_gen_enable, fb_gen_enable, done, aborted};
        if (mon_en) begin
            chk("strobe_onehot", 64'($countones(ev[9:2]) <= 1), 64'd1);
            if (ev !== 10'd0) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected", 64'(ev), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_event", 64'(ev), 64'(e));
                end
            end
            be_total += int'(byte_gen_enable);
            rc_total += int'(rc_gen_enable);
            br_total += int'(beat_req);
        end
        if (beat_req === 1'b1) begin
            wait_cnt++;
            beat_ack = auto_ack && (wait_cnt > ack_delay);
        end else begin
            wait_cnt = 0;
            beat_ack = 1'b0;
        end
    endtask

    task automatic push_xfer(input int words, input int rw);
        int row;
        row = 0;
        if (words != 0) begin
            exp_q.push_back(E_CLR);
            exp_q.push_back(E_LDB);
            exp_q.push_back(E_LDR);
            exp_q.push_back(E_LDM);
            for (int i = 0; i < words; i++) begin
                exp_q.push_back(E_BE);
                exp_q.push_back(E_ME);
                row++;
                if (rw != 0 && row == rw) begin
                    exp_q.push_back(E_RC);
                    row = 0;
                end
            end
        end
        exp_q.push_back(E_FB);
    endtask

    // Present a descriptor; returns after the accept edge, at cycle T+1.
    task automatic send(input logic [39:0] a, input logic [3:0] c, input int words, input int rw,
                        input bit keep_valid);
        cmd_addresses = a;
        cmd_control   = c;
        cmd_words     = 16'(words);
        cmd_row_words = 8'(rw);
        cmd_valid     = 1'b1;
        tick();
        if (!keep_valid) cmd_valid = 1'b0;
    endtask

    // Cycles from accept until done or aborted (bounded).
    task automatic wait_end(output int n);
        n = 1;
        while (done !== 1'b1 && aborted !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n, be0, rc0, br0, acks;
        clear_ctrl = 1'b1; cmd_valid = 1'b0; abort = 1'b0; beat_ack = 1'b0;
        cmd_addresses = 40'd0; cmd_control = 4'd0; cmd_words = 16'd0; cmd_row_words = 8'd0;
        repeat (3) tick();
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_latch_addr", 64'(latch_tr_addresses), 64'd0);
        chk("rst_latch_ctrl", 64'(latch_tr_control), 64'd0);
        chk("rst_outs", 64'({beat_req, clear_agu, byte_gen_ldinit, rc_gen_ldinit, mem_gen_ldinit,
            byte_gen_enable, mem_gen_enable, rc_gen_enable, fb_gen_enable, done, aborted}), 64'd0);
        clear_ctrl = 1'b0;
        mon_en = 1'b1;
        tick();

        // 4 words, 2 per row, immediate acks
        push_xfer(4, 2);
        send(40'hAB_CDEF_0123, 4'b0010, 4, 2, 1'b0);
        chk("t1_latch_addr", 64'(latch_tr_addresses), 64'hAB_CDEF_0123);
        chk("t1_latch_ctrl", 64'(latch_tr_control), 64'b0010);
        wait_end(n);
        chk("t1_done", 64'(done), 64'd1);
        chk("t1_latency", 64'(n), 64'(4 + 4 * 3 + 2 + 1));
        tick();
        chk("t1_idle", 64'(cmd_ready), 64'd1);
        chk("t1_latch_hold", 64'(latch_tr_addresses), 64'hAB_CDEF_0123);
        chk("t1_drain", 64'(exp_q.size()), 64'd0);

        // zero-length descriptor
        push_xfer(0, 0);
        send(40'h11_2233_4455, 4'h1, 0, 3, 1'b0);
        wait_end(n);
        chk("t2_done", 64'(done), 64'd1);
        chk("t2_latency", 64'(n), 64'd1);
        tick();
        chk("t2_idle", 64'(cmd_ready), 64'd1);
        chk("t2_drain", 64'(exp_q.size()), 64'd0);

        // 3 words, no row stepping, acks delayed 5 cycles
        ack_delay = 5;
        be0 = be_total; rc0 = rc_total; br0 = br_total;
        push_xfer(3, 0);
        send(40'h00_0000_0042, 4'h0, 3, 0, 1'b0);
        wait_end(n);
        chk("t3_done", 64'(done), 64'd1);
        chk("t3_latency", 64'(n), 64'(4 + 3 * (6 + 2) + 1));
        chk("t3_beat_req_cycles", 64'(br_total - br0), 64'd18);
        chk("t3_byte_en", 64'(be_total - be0), 64'd3);
        chk("t3_rc_en", 64'(rc_total - rc0), 64'd0);
        tick();
        chk("t3_drain", 64'(exp_q.size()), 64'd0);
        ack_delay = 0;

        // abort in IDLE is ignored
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle_abort_ready", 64'(cmd_ready), 64'd1);
        chk("idle_abort_busy", 64'(busy), 64'd0);

        // abort together with the 2nd beat_ack of a 4-word transfer
        be0 = be_total;
        exp_q.push_back(E_CLR); exp_q.push_back(E_LDB); exp_q.push_back(E_LDR);
        exp_q.push_back(E_LDM); exp_q.push_back(E_BE); exp_q.push_back(E_ME);
        exp_q.push_back(E_AB);
        send(40'h55_5555_5555, 4'h3, 4, 0, 1'b0);
        acks = 0;
        for (int i = 0; i < 100 && acks < 2; i++) begin
            if (beat_req === 1'b1 && beat_ack === 1'b1) acks++;
            if (acks < 2) tick();
        end
        chk("t4_reach_2nd_ack", 64'(acks), 64'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_aborted", 64'(aborted), 64'd1);
        chk("t4_clear_agu", 64'(clear_agu), 64'd1);
        chk("t4_done_low", 64'(done), 64'd0);
        chk("t4_byte_en", 64'(be_total - be0), 64'd1);
        tick();
        chk("t4_idle", 64'(cmd_ready), 64'd1);
        chk("t4_drain", 64'(exp_q.size()), 64'd0);

        // back-to-back with cmd_valid held high
        push_xfer(1, 0);
        push_xfer(1, 0);
        send(40'h0F_0F0F_0F0F, 4'h4, 1, 0, 1'b1);
        cmd_addresses = 40'h12_3456_789A;
        wait_end(n);
        chk("t5_done1", 64'(done), 64'd1);
        chk("t5_latency1", 64'(n), 64'd8);
        chk("t5_latch_old", 64'(latch_tr_addresses), 64'h0F_0F0F_0F0F);
        tick();
        chk("t5_ready_after_done", 64'(cmd_ready), 64'd1);
        tick();
        cmd_valid = 1'b0;
        chk("t5_second_clr", 64'(clear_agu), 64'd1);
        chk("t5_latch_new", 64'(latch_tr_addresses), 64'h12_3456_789A);
        wait_end(n);
        chk("t5_done2", 64'(done), 64'd1);
        tick();
        chk("t5_drain", 64'(exp_q.size()), 64'd0);

        // clear_ctrl during WAIT_BEAT
        auto_ack = 1'b0;
        exp_q.push_back(E_CLR); exp_q.push_back(E_LDB);
        exp_q.push_back(E_LDR); exp_q.push_back(E_LDM);
        send(40'h77_7777_7777, 4'h2, 4, 2, 1'b0);
        n = 0;
        while (beat_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("t6_wait_beat", 64'(beat_req), 64'd1);
        clear_ctrl = 1'b1;
        tick();
        clear_ctrl = 1'b0;
        chk("t6_idle", 64'({cmd_ready, busy}), 64'b10);
        chk("t6_outs", 64'({beat_req, clear_agu, byte_gen_ldinit, rc_gen_ldinit, mem_gen_ldinit,
            byte_gen_enable, mem_gen_enable, rc_gen_enable, fb_gen_enable, done, aborted}), 64'd0);
        repeat (3) tick();
        chk("t6_no_done_or_abort", 64'({done, aborted}), 64'd0);
        chk("t6_drain", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
